// File: rtl/ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge.sv
// -----------------------------------------------------------------------------
// ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge
//
// System-clock side of the sequencer CPU JTAG debug path.
//  - Synchronises the virtual-JTAG update strobes (vs_udr, vs_uir) into clk.
//  - On each completed DR scan, captures {ir_in, sr} into a small FIFO.
//  - The CPU debug logic drains the FIFO with a valid/ready handshake. Every
//    pop produces a one-hot take_action / take_no_action strobe on the channel
//    selected by the entry's IR.
//
// Ports:
//  clk, reset_n        : system clock, asynchronous active-low reset
//  vs_udr, vs_uir      : TCK-domain update levels (asynchronous to clk)
//  ir_in, sr           : virtual IR and scan shift register (quasi-static)
//  jdo, cmd_ir         : head-of-FIFO scan data and IR
//  cmd_valid/cmd_ready : consumer handshake (pop on valid & ready)
//  take_action         : one-hot strobe on pop when jdo[ACTION_BIT] = 1
//  take_no_action      : one-hot strobe on pop when jdo[ACTION_BIT] = 0
//  uir_pulse           : one-cycle strobe per vs_uir rising edge
//  overflow            : sticky flag, a scan was dropped on a full FIFO
//  overflow_clr        : clears overflow (a new drop wins over the clear)
//  fifo_level          : number of occupied entries
// -----------------------------------------------------------------------------
module ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge #(
    parameter int DR_W       = 38,
    parameter int IR_W       = 2,
    parameter int SYNC_DEPTH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ACTION_BIT = 34,
    localparam int NCH       = 2**IR_W,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int PW        = AW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_udr,
    input  logic            vs_uir,
    input  logic [IR_W-1:0] ir_in,
    input  logic [DR_W-1:0] sr,
    output logic [DR_W-1:0] jdo,
    output logic [IR_W-1:0] cmd_ir,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action,
    output logic            uir_pulse,
    output logic            overflow,
    input  logic            overflow_clr,
    output logic [PW-1:0]   fifo_level
);

    // Synchroniser chains, edge-detect delay flops and registered rise strobes
    logic [SYNC_DEPTH-1:0] udr_sync_r;
    logic [SYNC_DEPTH-1:0] uir_sync_r;
    logic                  udr_dly_r;
    logic                  uir_dly_r;
    logic                  udr_rise_r;
    logic                  uir_rise_r;

    // FIFO storage and pointers (one extra pointer bit distinguishes full/empty)
    logic [DR_W-1:0]       data_mem_r [FIFO_DEPTH];
    logic [IR_W-1:0]       ir_mem_r   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    // Strobe synchronisers; the rise detect is registered so the capture of
    // {ir_in, sr} happens one cycle after the synchronised level goes high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_r <= {SYNC_DEPTH{1'b0}};
            uir_sync_r <= {SYNC_DEPTH{1'b0}};
            udr_dly_r  <= 1'b0;
            uir_dly_r  <= 1'b0;
            udr_rise_r <= 1'b0;
            uir_rise_r <= 1'b0;
        end else begin
            udr_sync_r <= {udr_sync_r[SYNC_DEPTH-2:0], vs_udr};
            uir_sync_r <= {uir_sync_r[SYNC_DEPTH-2:0], vs_uir};
            udr_dly_r  <= udr_sync_r[SYNC_DEPTH-1];
            uir_dly_r  <= uir_sync_r[SYNC_DEPTH-1];
            udr_rise_r <= udr_sync_r[SYNC_DEPTH-1] & ~udr_dly_r;
            uir_rise_r <= uir_sync_r[SYNC_DEPTH-1] & ~uir_dly_r;
        end
    end

    // FIFO status and push/pop/drop decisions
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s   = ~empty_s & cmd_ready;
        // A pop in the same cycle frees the head slot, so a full FIFO still
        // accepts the push; only push-without-pop on full drops the scan.
        push_s  = udr_rise_r & (~full_s | pop_s);
        drop_s  = udr_rise_r & full_s & ~pop_s;
    end

    // FIFO storage; cleared on reset so the head outputs never show X
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= {DR_W{1'b0}};
                ir_mem_r[i]   <= {IR_W{1'b0}};
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r[AW-1:0]] <= sr;
            ir_mem_r[wr_ptr_r[AW-1:0]]   <= ir_in;
        end else begin
            data_mem_r <= data_mem_r;
            ir_mem_r   <= ir_mem_r;
        end
    end

    // Read/write pointers; wrap-around is plain binary overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

    // Registered update-IR strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_pulse <= 1'b0;
        end else begin
            uir_pulse <= uir_rise_r;
        end
    end

    // Head entry and occupancy; when empty the head location simply holds
    // whatever it last contained (zero after reset)
    assign jdo        = data_mem_r[rd_ptr_r[AW-1:0]];
    assign cmd_ir     = ir_mem_r[rd_ptr_r[AW-1:0]];
    assign cmd_valid  = ~empty_s;
    assign fifo_level = wr_ptr_r - rd_ptr_r;

    // Per-channel action strobes, zero-latency with respect to the pop
    always_comb begin
        take_action    = {NCH{1'b0}};
        take_no_action = {NCH{1'b0}};
        if (pop_s) begin
            if (jdo[ACTION_BIT]) begin
                take_action[cmd_ir] = 1'b1;
            end else begin
                take_no_action[cmd_ir] = 1'b1;
            end
        end else begin
            take_action    = {NCH{1'b0}};
            take_no_action = {NCH{1'b0}};
        end
    end

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge.
// A default-parameter instance is exercised with randomised scan data against
// a queue-based reference model; a second instance (IR_W=3, SYNC_DEPTH=3,
// FIFO_DEPTH=8, DR_W=40) covers the parameter sweep.
// -----------------------------------------------------------------------------
module tb_ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge;

    logic        clk;
    logic        reset_n;

    // default instance
    logic        vs_udr, vs_uir, cmd_ready, overflow_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir;
    logic        cmd_valid, uir_pulse, overflow;
    logic [3:0]  take_action, take_no_action;
    logic [2:0]  fifo_level;

    // sweep instance
    logic        vs_udr2, vs_uir2, cmd_ready2, overflow_clr2;
    logic [2:0]  ir_in2;
    logic [39:0] sr2;
    logic [39:0] jdo2;
    logic [2:0]  cmd_ir2;
    logic        cmd_valid2, uir_pulse2, overflow2;
    logic [7:0]  take_action2, take_no_action2;
    logic [3:0]  fifo_level2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queue of {ir, data}, sticky overflow
    logic [39:0] model_q[$];
    logic        model_ovf;

    ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .jdo(jdo), .cmd_ir(cmd_ir),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .take_action(take_action), .take_no_action(take_no_action),
        .uir_pulse(uir_pulse), .overflow(overflow),
        .overflow_clr(overflow_clr), .fifo_level(fifo_level)
    );

    ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge #(
        .DR_W(40), .IR_W(3), .SYNC_DEPTH(3), .FIFO_DEPTH(8), .ACTION_BIT(34)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr2), .vs_uir(vs_uir2),
        .ir_in(ir_in2), .sr(sr2), .jdo(jdo2), .cmd_ir(cmd_ir2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .take_action(take_action2), .take_no_action(take_no_action2),
        .uir_pulse(uir_pulse2), .overflow(overflow2),
        .overflow_clr(overflow_clr2), .fifo_level(fifo_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_act(input logic [39:0] e);
        return e[34] ? (4'b0001 << e[39:38]) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_noact(input logic [39:0] e);
        return e[34] ? 4'b0000 : (4'b0001 << e[39:38]);
    endfunction

    function automatic logic [39:0] rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    // one full vs_udr pulse (4 cycles high, 4 low) with ready held by caller
    task automatic scan(input logic [39:0] e);
        ir_in  = e[39:38];
        sr     = e[37:0];
        vs_udr = 1'b1;
        repeat (4) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    // scan issued with cmd_ready=0, model updated with drop rule
    task automatic scan_nopop(input logic [39:0] e);
        scan(e);
        if (model_q.size() < 4) model_q.push_back(e);
        else model_ovf = 1'b1;
    endtask

    // drain everything the model holds, checking order and strobes
    task automatic drain();
        logic [39:0] e;
        cmd_ready = 1'b1;
        #1;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            check("drain_valid", cmd_valid, 1);
            check("drain_jdo", jdo, e[37:0]);
            check("drain_ir", cmd_ir, e[39:38]);
            check("drain_act", take_action, exp_act(e));
            check("drain_noact", take_no_action, exp_noact(e));
            tick();
        end
        check("drain_empty", cmd_valid, 0);
        check("drain_act_idle", {take_action, take_no_action}, 0);
        cmd_ready = 1'b0;
    endtask

    // push while full with a pop landing in the same cycle as the rise
    task automatic simul(input logic [39:0] e);
        ir_in  = e[39:38];
        sr     = e[37:0];
        vs_udr = 1'b1;
        repeat (3) tick();
        cmd_ready = 1'b1;
        #1;
        check("simul_jdo", jdo, model_q[0][37:0]);
        check("simul_act", take_action, exp_act(model_q[0]));
        check("simul_noact", take_no_action, exp_noact(model_q[0]));
        tick();
        cmd_ready = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(e);
        check("simul_level", fifo_level, model_q.size());
        check("simul_ovf", overflow, 0);
        tick();
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [39:0] e;
        logic        seen;

        reset_n = 1'b0;
        vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; overflow_clr = 1'b0;
        ir_in = 2'd0; sr = 38'd0;
        vs_udr2 = 1'b0; vs_uir2 = 1'b0; cmd_ready2 = 1'b0; overflow_clr2 = 1'b0;
        ir_in2 = 3'd0; sr2 = 40'd0;
        model_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_jdo", jdo, 0);
        check("rst_ir", cmd_ir, 0);
        check("rst_level", fifo_level, 0);
        check("rst_misc", {overflow, uir_pulse, take_action, take_no_action}, 0);
        reset_n = 1'b1;
        tick();

        // single command, action on channel 0, latency to cmd_valid
        e = rand_entry();
        e[39:38] = 2'd0;
        e[34] = 1'b1;
        cmd_ready = 1'b1;
        ir_in = e[39:38]; sr = e[37:0]; vs_udr = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t1_lat", cmd_valid, 0);
        end
        tick();
        check("t1_valid", cmd_valid, 1);
        check("t1_act", take_action, 4'b0001);
        check("t1_noact", take_no_action, 4'b0000);
        check("t1_jdo", jdo, e[37:0]);
        tick();
        check("t1_valid_drop", cmd_valid, 0);
        check("t1_act_drop", take_action, 4'b0000);
        vs_udr = 1'b0;
        repeat (4) tick();

        // uir pulse timing; FIFO unaffected
        vs_uir = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("uir_lat", uir_pulse, 0);
        end
        tick();
        check("uir_pulse", uir_pulse, 1);
        tick();
        check("uir_width", uir_pulse, 0);
        check("uir_level", fifo_level, 0);
        vs_uir = 1'b0;
        repeat (4) tick();

        // no-action decode on channel 2
        e = rand_entry();
        e[39:38] = 2'd2;
        e[34] = 1'b0;
        ir_in = e[39:38]; sr = e[37:0]; vs_udr = 1'b1;
        for (int k = 0; k < 10 && !cmd_valid; k++) tick();
        check("t2_valid", cmd_valid, 1);
        check("t2_noact", take_no_action, 4'b0100);
        check("t2_act", take_action, 4'b0000);
        check("t2_jdo", jdo, e[37:0]);
        tick();
        check("t2_noact_drop", take_no_action, 4'b0000);
        vs_udr = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) tick();

        // backpressure and overflow: five scans into a 4-deep FIFO
        for (int k = 0; k < 5; k++) scan_nopop(rand_entry());
        check("bp_level", fifo_level, model_q.size());
        check("bp_ovf", overflow, model_ovf);
        drain();
        check("bp_ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("bp_ovf_clr", overflow, 0);

        // full with simultaneous push/pop, pointer wrap keeps order
        for (int k = 0; k < 4; k++) scan_nopop(rand_entry());
        check("full_level", fifo_level, 4);
        for (int k = 0; k < 4; k++) simul(rand_entry());
        drain();
        check("full_ovf_end", overflow, 0);

        // reset mid-operation with entries queued and uir pulse pending
        for (int k = 0; k < 3; k++) scan_nopop(rand_entry());
        check("mr_level_pre", fifo_level, 3);
        vs_uir = 1'b1;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_valid", cmd_valid, 0);
        check("mr_level", fifo_level, 0);
        check("mr_jdo", jdo, 0);
        check("mr_ir", cmd_ir, 0);
        check("mr_misc", {overflow, uir_pulse, take_action, take_no_action}, 0);
        vs_uir = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cmd_valid || uir_pulse) seen = 1'b1;
        end
        check("mr_quiet", seen, 0);
        scan_nopop(rand_entry());
        check("mr_new_level", fifo_level, 1);
        drain();

        // parameter sweep instance: latency 5 edges, channel 7 action
        sr2 = 40'({$urandom, $urandom});
        sr2[34] = 1'b1;
        ir_in2 = 3'd7;
        cmd_ready2 = 1'b1;
        vs_udr2 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("sw_lat", cmd_valid2, 0);
        end
        tick();
        check("sw_valid", cmd_valid2, 1);
        check("sw_act", take_action2, 8'b1000_0000);
        check("sw_noact", take_no_action2, 8'b0000_0000);
        check("sw_jdo", jdo2, sr2);
        tick();
        check("sw_valid_drop", cmd_valid2, 0);
        vs_udr2 = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge.md
# ddr2_v10_1_sequencer_cpu_jtag_debug_cmd_bridge

Parametrised system-clock side of the sequencer CPU JTAG debug path. It synchronises the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) into `clk`, captures each completed data-register scan (`sr`) together with its instruction (`ir_in`), and queues the pair in a small FIFO. The CPU debug logic drains the FIFO with a valid/ready handshake. Each drained command produces per-instruction take_action / take_no_action strobes, generalising the fixed 2-bit-IR, single-entry, no-backpressure sysclk stage.

## Interface
Parameters:
- `DR_W`, 38: data-register (scan chain) width.
- `IR_W`, 2: virtual IR width; number of instruction channels `NCH = 2**IR_W`.
- `SYNC_DEPTH`, 2: synchroniser flops per strobe; legal values ≥ 2.
- `FIFO_DEPTH`, 4: command entries; power of two, ≥ 2.
- `ACTION_BIT`, 34: bit of the captured scan that selects action (1) or no-action (0); must be < `DR_W`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vs_udr`  in  1  update-DR level from the TCK domain; asynchronous to `clk`.
- `vs_uir`  in  1  update-IR level from the TCK domain; asynchronous to `clk`.
- `ir_in`  in  IR_W  current virtual IR; quasi-static around an update.
- `sr`  in  DR_W  TCK-domain shift register; quasi-static around an update.
- `jdo`  out  DR_W  scan data of the FIFO head entry.
- `cmd_ir`  out  IR_W  IR of the FIFO head entry.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_ready`  in  1  consumer accepts the head entry.
- `take_action`  out  NCH  one-hot strobe on pop: `[cmd_ir]` set when `jdo[ACTION_BIT]` = 1.
- `take_no_action`  out  NCH  one-hot strobe on pop: `[cmd_ir]` set when `jdo[ACTION_BIT]` = 0.
- `uir_pulse`  out  1  one-cycle strobe per `vs_uir` rising edge.
- `overflow`  out  1  sticky flag: a scan was dropped because the FIFO was full.
- `overflow_clr`  in  1  clears `overflow`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- Synchronisers: `vs_udr` and `vs_uir` each pass through a `SYNC_DEPTH`-flop chain, followed by one delay flop. `udr_rise = sync_last & ~delay`. `uir_rise` is formed the same way.
- Push: when `udr_rise` = 1, write `{ir_in, sr}` (sampled that cycle) to the tail.
- If the FIFO is full and no pop occurs in the same cycle, drop the entry and set `overflow`.
- Pop: occurs when `cmd_valid & cmd_ready`. The read pointer advances.
- In the pop cycle, `take_action`/`take_no_action` are driven combinationally from the head entry. `jdo` holds that same entry throughout the cycle.
- Simultaneous push and pop:
  - When full: both are performed, the level is unchanged, and `overflow` is not set.
  - When empty: the pop is not possible (`cmd_valid` = 0); the push is performed.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide. Full = MSBs differ and LSBs are equal. Wrap-around is natural binary overflow.
- `jdo`/`cmd_ir` when empty: hold the last-read storage location. Content is don't-care but must be stable (no X after reset, since storage resets to 0).
- `uir_pulse` is registered from `uir_rise`. It has no effect on FIFO contents.
- `overflow`: set has priority over `overflow_clr` in the same cycle.
- Reset (any time, including mid-operation): synchronisers, pointers, storage, `overflow` and `uir_pulse` all go to 0. Consequently `cmd_valid`, `take_*`, `fifo_level`, `jdo` and `cmd_ir` are all 0. Any pending entries are discarded.

## Timing
- Edge numbering: the `clk` edge that first samples `vs_udr` = 1 is edge 1.
  - `udr_rise` is high in the cycle after edge SYNC_DEPTH+1.
  - The entry is written at edge SYNC_DEPTH+2.
  - `cmd_valid` rises after edge SYNC_DEPTH+2.
- `vs_uir` rise to `uir_pulse`: high for exactly one cycle after edge SYNC_DEPTH+2.
- `take_*`: zero-latency relative to the handshake, exactly one cycle wide per pop. Back-to-back pops yield consecutive strobes.
- `vs_udr`/`vs_uir` pulses must stay high for at least SYNC_DEPTH+1 `clk` periods, and low for at least as long between pulses. Shorter pulses may be missed; this is not flagged.
- `ir_in`/`sr` must be stable from the `vs_udr` rise until SYNC_DEPTH+3 `clk` edges later.

## Test plan
- Single command, default parameters:
  - Stimulus: `ir_in`=0, `sr` with bit 34 = 1, one `vs_udr` pulse, `cmd_ready`=1.
  - Required: `cmd_valid` rises after edge 4; in that cycle `take_action`=4'b0001, `take_no_action`=0, `jdo`=`sr`; `cmd_valid` drops next cycle.
- No-action decode:
  - Stimulus: `ir_in`=2, `sr[34]`=0.
  - Required: `take_no_action`=4'b0100 for one cycle; `take_action`=0.
- Backpressure and overflow:
  - Stimulus: `cmd_ready`=0, five `vs_udr` pulses.
  - Required: `fifo_level` = 4, `overflow` = 1, the fifth scan is lost.
  - Then: raise `cmd_ready`. Required: four pops in order, data matching scans 1–4; `overflow` stays 1 until an `overflow_clr` pulse, then reads 0.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, `cmd_ready`=1 in the same cycle as `udr_rise`.
  - Required: `fifo_level` stays 4, `overflow` stays 0; after 8 commands through the FIFO, pointer wrap-around still preserves order.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 with 3 entries queued and `uir_pulse` pending.
  - Required: all outputs 0 immediately (asynchronous); after release, `cmd_valid` stays 0 until a new `vs_udr` pulse.
- Parameter sweep:
  - Stimulus: `IR_W`=3, `SYNC_DEPTH`=3, `FIFO_DEPTH`=8, `DR_W`=40; `ir_in`=7 with the action bit set.
  - Required: latency to `cmd_valid` is 5 edges; `take_action`=8'b1000_0000.
